// File: rtl/mips_defs_pkg.sv
// Shared data-memory definitions: memory op encoding, access helpers and the M/W register payload.
package mips_defs;

  localparam int unsigned DMEM_WORDS_DEF = 4096;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  typedef struct packed {
    mem_op_t     op;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  lo2;
    logic [31:0] word;
  } mw_reg_t;

  function automatic logic is_load(input mem_op_t op);
    return op inside {MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {MEM_SW, MEM_SH, MEM_SB};
  endfunction

  function automatic acc_size_t access_size(input mem_op_t op);
    case (op)
      MEM_LW, MEM_SW:          return SZ_WORD;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
      default:                 return SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_data_ext.sv
// W-stage load lane select and sign/zero extension of the captured memory word.
module data_ext
  import mips_defs::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  lo2,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        we_ok
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = lo2[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[{lo2, 3'b000} +: 8];

  always_comb begin
    data  = '0;
    we_ok = 1'b0;
    case (op)
      MEM_LW:  begin data = word;                                we_ok = 1'b1; end
      MEM_LH:  begin data = {{16{half_sel[15]}}, half_sel};      we_ok = 1'b1; end
      MEM_LHU: begin data = {16'h0000, half_sel};                we_ok = 1'b1; end
      MEM_LB:  begin data = {{24{byte_sel[7]}}, byte_sel};       we_ok = 1'b1; end
      MEM_LBU: begin data = {24'h000000, byte_sel};              we_ok = 1'b1; end
      default: begin data = '0;                                  we_ok = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side data-memory access: M-stage store lane generation and fault check,
// M/W load capture, W-stage load extension, store counter and sticky fault flag.
module mem_access_unit
  import mips_defs::*;
#(
  parameter int unsigned DMEM_WORDS  = DMEM_WORDS_DEF,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        m_valid,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_rt,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_load_we,
  output logic [4:0]  w_load_rd,
  output logic [31:0] w_load_data,
  output logic [31:0] w_inst_addr,
  output logic        misalign_err,
  output logic [31:0] store_count
);

  mem_op_t     op_m;
  logic [1:0]  a;
  logic        is_mem;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [3:0]  lane_en;

  mw_reg_t     mw_d, mw_q;
  logic [31:0] store_count_d, store_count_q;
  logic        err_d, err_q;

  logic [31:0] ext_data;
  logic        ext_we_ok;

  assign op_m        = mem_op_t'(m_op);
  assign a           = m_addr[1:0];
  assign is_mem      = is_load(op_m) || is_store(op_m);
  assign m_data_addr = m_addr;
  assign m_inst_addr = m_pc;

  // Alignment and range fault for the M-stage access.
  always_comb begin
    misaligned = 1'b0;
    case (access_size(op_m))
      SZ_WORD: misaligned = (a != 2'b00);
      SZ_HALF: misaligned = a[0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = CHECK_RANGE && ({2'b00, m_addr[31:2]} >= 32'(DMEM_WORDS));
    fault        = is_mem && (misaligned || out_of_range);
  end

  // Store lane enables and lane-replicated write data; suppressed on fault, stall or reset.
  always_comb begin
    lane_en      = 4'b0000;
    m_data_wdata = m_rt;
    case (op_m)
      MEM_SW: lane_en = 4'b1111;
      MEM_SH: begin
        lane_en      = 4'(4'b0011 << a);
        m_data_wdata = {2{m_rt[15:0]}};
      end
      MEM_SB: begin
        lane_en      = 4'(4'b0001 << a);
        m_data_wdata = {4{m_rt[7:0]}};
      end
      default: lane_en = 4'b0000;
    endcase
    m_data_byteen = (m_valid && en && !reset && !fault) ? lane_en : 4'b0000;
  end

  always_comb begin
    mw_d          = mw_q;
    store_count_d = store_count_q;
    err_d         = err_q;
    if (en) begin
      mw_d.op   = (m_valid && is_mem && !fault) ? op_m : MEM_NONE;
      mw_d.rd   = m_rd;
      mw_d.pc   = m_pc;
      mw_d.lo2  = a;
      mw_d.word = m_data_rdata;
    end
    if (m_data_byteen != 4'b0000) store_count_d = store_count_q + 32'd1;
    if (m_valid && en && fault)   err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mw_q          <= '0;
      store_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      mw_q          <= mw_d;
      store_count_q <= store_count_d;
      err_q         <= err_d;
    end
  end

  data_ext u_data_ext (
    .op    (mw_q.op),
    .lo2   (mw_q.lo2),
    .word  (mw_q.word),
    .data  (ext_data),
    .we_ok (ext_we_ok)
  );

  assign w_load_we    = ext_we_ok && (mw_q.rd != 5'd0);
  assign w_load_rd    = mw_q.rd;
  assign w_load_data  = ext_data;
  assign w_inst_addr  = mw_q.pc;
  assign misalign_err = err_q;
  assign store_count  = store_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a second instance that has the range check disabled.
module tb_mem_access_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                         OP_LB = 4'd4, OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

  logic        clk = 1'b0;
  logic        reset, en, m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_rt, m_pc, m_data_rdata;
  logic [4:0]  m_rd;

  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, w_load_data, w_inst_addr, store_count;
  logic [3:0]  m_data_byteen;
  logic        w_load_we, misalign_err;
  logic [4:0]  w_load_rd;

  logic [31:0] m_data_addr1, m_data_wdata1, m_inst_addr1, w_load_data1, w_inst_addr1, store_count1;
  logic [3:0]  m_data_byteen1;
  logic        w_load_we1, misalign_err1;
  logic [4:0]  w_load_rd1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DMEM_WORDS(4096), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_rt(m_rt), .m_pc(m_pc), .m_rd(m_rd), .m_data_rdata(m_data_rdata),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr), .w_load_we(w_load_we), .w_load_rd(w_load_rd),
    .w_load_data(w_load_data), .w_inst_addr(w_inst_addr), .misalign_err(misalign_err),
    .store_count(store_count)
  );

  mem_access_unit #(.DMEM_WORDS(4096), .CHECK_RANGE(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .en(en), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_rt(m_rt), .m_pc(m_pc), .m_rd(m_rd), .m_data_rdata(m_data_rdata),
    .m_data_addr(m_data_addr1), .m_data_wdata(m_data_wdata1), .m_data_byteen(m_data_byteen1),
    .m_inst_addr(m_inst_addr1), .w_load_we(w_load_we1), .w_load_rd(w_load_rd1),
    .w_load_data(w_load_data1), .w_inst_addr(w_inst_addr1), .misalign_err(misalign_err1),
    .store_count(store_count1)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] ld;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [31:0] rdata, input logic [4:0] rd,
                       input logic [31:0] pc);
    m_valid = v; m_op = op; m_addr = addr; m_rt = rt;
    m_data_rdata = rdata; m_rd = rd; m_pc = pc;
  endtask

  initial begin
    //          valid op      addr          rt            rdata         rd  be       wd            we    ld            err   cnt
    vecs[0]  = '{1'b1, OP_SB,  32'h00000003, 32'h123456AB, 32'h0,        5'd0,  4'b1000, 32'hABABABAB, 1'b0, 32'h0,        1'b0, 32'd1};
    vecs[1]  = '{1'b1, OP_LB,  32'h00000002, 32'h0,        32'h00800000, 5'd5,  4'b0000, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 32'd1};
    vecs[2]  = '{1'b1, OP_LBU, 32'h00000002, 32'h0,        32'h00800000, 5'd5,  4'b0000, 32'h0,        1'b1, 32'h00000080, 1'b0, 32'd1};
    vecs[3]  = '{1'b1, OP_SW,  32'h00000010, 32'hDEADBEEF, 32'h0,        5'd0,  4'b1111, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'd2};
    vecs[4]  = '{1'b1, OP_SH,  32'h00000006, 32'h0000CAFE, 32'h0,        5'd0,  4'b1100, 32'hCAFECAFE, 1'b0, 32'h0,        1'b0, 32'd3};
    vecs[5]  = '{1'b1, OP_LH,  32'h00000022, 32'h0,        32'h80017FFF, 5'd3,  4'b0000, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 32'd3};
    vecs[6]  = '{1'b1, OP_LHU, 32'h00000020, 32'h0,        32'h80019ABC, 5'd3,  4'b0000, 32'h0,        1'b1, 32'h00009ABC, 1'b0, 32'd3};
    vecs[7]  = '{1'b1, OP_LW,  32'h00000040, 32'h0,        32'h13579BDF, 5'd31, 4'b0000, 32'h0,        1'b1, 32'h13579BDF, 1'b0, 32'd3};
    vecs[8]  = '{1'b1, OP_LB,  32'h00000001, 32'h0,        32'h00007F00, 5'd2,  4'b0000, 32'h0,        1'b1, 32'h0000007F, 1'b0, 32'd3};
    vecs[9]  = '{1'b1, OP_LW,  32'h00000000, 32'h0,        32'hFFFFFFFF, 5'd0,  4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 32'd3};
    vecs[10] = '{1'b0, OP_SW,  32'h00000000, 32'h00000001, 32'h0,        5'd0,  4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 32'd3};
    vecs[11] = '{1'b1, OP_SB,  32'h00000000, 32'h00000055, 32'h0,        5'd0,  4'b0001, 32'h55555555, 1'b0, 32'h0,        1'b0, 32'd4};
    vecs[12] = '{1'b1, OP_SH,  32'h00000001, 32'h0000BEEF, 32'h0,        5'd0,  4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 32'd4};
    vecs[13] = '{1'b1, OP_SB,  32'h00000002, 32'h00000077, 32'h0,        5'd0,  4'b0100, 32'h77777777, 1'b0, 32'h0,        1'b1, 32'd5};
    vecs[14] = '{1'b1, OP_LH,  32'h00004000, 32'h0,        32'h00001234, 5'd4,  4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 32'd5};
    vecs[15] = '{1'b1, OP_LW,  32'h00003FFC, 32'h0,        32'hA5A5A5A5, 5'd4,  4'b0000, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b1, 32'd5};

    reset = 1'b1; en = 1'b0;
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_byteen", 32'(m_data_byteen), 32'h0);
    chk("rst_we", 32'(w_load_we), 32'h0);
    chk("rst_rd", 32'(w_load_rd), 32'h0);
    chk("rst_data", w_load_data, 32'h0);
    chk("rst_iaddr", w_inst_addr, 32'h0);
    chk("rst_err", 32'(misalign_err), 32'h0);
    chk("rst_cnt", store_count, 32'h0);
    reset = 1'b0; en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].rdata, vecs[i].rd,
            32'h1000 + 32'(i) * 32'd4);
      #1;
      chk($sformatf("v%0d_byteen", i), 32'(m_data_byteen), 32'(vecs[i].be));
      if (vecs[i].be != 4'b0000) chk($sformatf("v%0d_wdata", i), m_data_wdata, vecs[i].wd);
      chk($sformatf("v%0d_daddr", i), m_data_addr, vecs[i].addr);
      chk($sformatf("v%0d_iaddr", i), m_inst_addr, 32'h1000 + 32'(i) * 32'd4);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), 32'(w_load_we), 32'(vecs[i].we));
      if (vecs[i].we) chk($sformatf("v%0d_ldata", i), w_load_data, vecs[i].ld);
      chk($sformatf("v%0d_err", i), 32'(misalign_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_cnt", i), store_count, vecs[i].cnt);
      chk($sformatf("v%0d_wpc", i), w_inst_addr, 32'h1000 + 32'(i) * 32'd4);
    end

    // Stall: W holds and stores have no effect while en=0.
    @(negedge clk);
    drive(1'b1, OP_LW, 32'h00000008, 32'h0, 32'h11111111, 5'd7, 32'h00000500);
    @(posedge clk); #1;
    chk("hold_pre_we", 32'(w_load_we), 32'h1);
    chk("hold_pre_data", w_load_data, 32'h11111111);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en = 1'b0;
      drive(1'b1, OP_SW, 32'h00000000, 32'(k), 32'hABCD0000 + 32'(k), 5'd9, 32'h00000600);
      #1;
      chk($sformatf("hold%0d_byteen", k), 32'(m_data_byteen), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_we", k), 32'(w_load_we), 32'h1);
      chk($sformatf("hold%0d_data", k), w_load_data, 32'h11111111);
      chk($sformatf("hold%0d_wpc", k), w_inst_addr, 32'h00000500);
      chk($sformatf("hold%0d_cnt", k), store_count, 32'd5);
    end

    // Reset while a store is in M and a load is in W.
    @(negedge clk);
    en = 1'b1;
    drive(1'b1, OP_LW, 32'h0000000C, 32'h0, 32'h22222222, 5'd9, 32'h00000700);
    @(posedge clk); #1;
    chk("rstmid_pre_we", 32'(w_load_we), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, OP_SW, 32'h00000000, 32'hFFFFFFFF, 32'h0, 5'd0, 32'h00000704);
    #1;
    chk("rstmid_byteen", 32'(m_data_byteen), 32'h0);
    @(posedge clk); #1;
    chk("rstmid_we", 32'(w_load_we), 32'h0);
    chk("rstmid_data", w_load_data, 32'h0);
    chk("rstmid_wpc", w_inst_addr, 32'h0);
    chk("rstmid_cnt", store_count, 32'h0);
    chk("rstmid_err", 32'(misalign_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Word 4096: out of range with the check on, a normal load with it off.
    drive(1'b1, OP_LH, 32'h00004000, 32'h0, 32'h00008234, 5'd4, 32'h00000800);
    @(posedge clk); #1;
    chk("range_we", 32'(w_load_we), 32'h0);
    chk("range_err", 32'(misalign_err), 32'h1);
    chk("norange_we", 32'(w_load_we1), 32'h1);
    chk("norange_data", w_load_data1, 32'hFFFF8234);
    chk("norange_err", 32'(misalign_err1), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Sticky flag needs both m_valid and en.
    drive(1'b0, OP_LW, 32'h00000002, 32'h0, 32'h0, 5'd6, 32'h00000900);
    @(posedge clk); #1;
    chk("mis_novalid_err", 32'(misalign_err), 32'h0);
    @(negedge clk);
    en = 1'b0;
    drive(1'b1, OP_LW, 32'h00000002, 32'h0, 32'h0, 5'd6, 32'h00000900);
    @(posedge clk); #1;
    chk("mis_noen_err", 32'(misalign_err), 32'h0);
    @(negedge clk);
    en = 1'b1;
    drive(1'b1, OP_LW, 32'h00000002, 32'h0, 32'h33333333, 5'd6, 32'h00000900);
    @(posedge clk); #1;
    chk("mis_lw_err", 32'(misalign_err), 32'h1);
    chk("mis_lw_we", 32'(w_load_we), 32'h0);
    @(negedge clk);
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    @(posedge clk); #1;
    chk("mis_sticky_err", 32'(misalign_err), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
